// File: rtl/otter_io_pkg.sv
// Shared register map, timer control layout and timer state encoding for the
// OTTER IOBUS responder.
package otter_io_pkg;

  localparam logic [7:0] SW_OFS     = 8'h00;
  localparam logic [7:0] LEDS_OFS   = 8'h20;
  localparam logic [7:0] SSEG_OFS   = 8'h40;
  localparam logic [7:0] TCTRL_OFS  = 8'h60;
  localparam logic [7:0] TLOAD_OFS  = 8'h64;
  localparam logic [7:0] TCOUNT_OFS = 8'h68;
  localparam logic [7:0] TSTAT_OFS  = 8'h6C;

  localparam int TCTRL_EN_BIT    = 0;
  localparam int TCTRL_AUTO_BIT  = 1;
  localparam int TCTRL_IE_BIT    = 2;
  localparam int TCTRL_PRESC_LSB = 8;
  localparam int TCTRL_PRESC_W   = 8;

  typedef struct packed {
    logic [TCTRL_PRESC_W-1:0] presc;
    logic                     ie;
    logic                     auto;
    logic                     en;
  } tctrl_t;

  typedef enum logic {
    T_IDLE = 1'b0,
    T_RUN  = 1'b1
  } tstate_e;

  // Bus image of TCTRL; unused bits read as zero.
  function automatic logic [31:0] tctrl_word(input tctrl_t c);
    logic [31:0] w;
    w = 32'h0;
    w[TCTRL_PRESC_LSB +: TCTRL_PRESC_W] = c.presc;
    w[TCTRL_IE_BIT]   = c.ie;
    w[TCTRL_AUTO_BIT] = c.auto;
    w[TCTRL_EN_BIT]   = c.en;
    return w;
  endfunction

endpackage

// File: rtl/otter_io_timer.sv
// Prescaled countdown timer: control/reload registers, count, pending flag
// and the registered interrupt line.
module otter_io_timer
  import otter_io_pkg::*;
#(
  parameter int PRESCALE_W = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_wr_i,
  input  logic [31:0] load_val_i,
  input  logic        ctrl_wr_i,
  input  tctrl_t      ctrl_val_i,
  input  logic        w1c_i,
  output logic [31:0] count_o,
  output logic [31:0] tload_o,
  output tctrl_t      ctrl_o,
  output logic        pend_o,
  output logic        en_o,
  output logic        intr_o
);

  tstate_e               state_q, state_d;
  tctrl_t                ctrl_q, ctrl_d;
  logic [31:0]           tload_q, tload_d;
  logic [31:0]           count_q, count_d;
  logic [PRESCALE_W-1:0] psc_q, psc_d;
  logic                  pend_q, pend_d;
  logic                  intr_q;
  logic                  psc_wrap;
  logic                  tick;
  logic                  expire;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= T_IDLE;
    else       state_q <= state_d;
  end

  // Next state: a control write always decides EN; otherwise a one-shot
  // expiry drops back to idle.
  always_comb begin
    state_d = state_q;
    if (ctrl_wr_i)
      state_d = ctrl_val_i.en ? T_RUN : T_IDLE;
    else if (expire && !ctrl_q.auto)
      state_d = T_IDLE;
  end

  // FSM outputs: a TLOAD write swallows the tick of its cycle.
  always_comb begin
    psc_wrap = (psc_q == PRESCALE_W'(ctrl_q.presc));
    tick     = (state_q == T_RUN) && psc_wrap && !load_wr_i;
    expire   = tick && (count_q <= 32'd1);
  end

  always_comb begin
    ctrl_d  = ctrl_wr_i ? ctrl_val_i : ctrl_q;
    tload_d = load_wr_i ? load_val_i : tload_q;

    psc_d = psc_q + PRESCALE_W'(1);
    if (load_wr_i || state_q != T_RUN || psc_wrap)
      psc_d = '0;

    count_d = count_q;
    if (load_wr_i)
      count_d = load_val_i;
    else if (expire)
      count_d = ctrl_q.auto ? tload_q : 32'd0;
    else if (tick)
      count_d = count_q - 32'd1;

    pend_d = pend_q;
    if (expire)
      pend_d = 1'b1;
    else if (w1c_i)
      pend_d = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q  <= '0;
      tload_q <= '0;
      count_q <= '0;
      psc_q   <= '0;
      pend_q  <= 1'b0;
      intr_q  <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      tload_q <= tload_d;
      count_q <= count_d;
      psc_q   <= psc_d;
      pend_q  <= pend_d;
      intr_q  <= pend_q & ctrl_q.ie;
    end
  end

  always_comb begin
    ctrl_o    = ctrl_q;
    ctrl_o.en = (state_q == T_RUN);
  end

  assign count_o = count_q;
  assign tload_o = tload_q;
  assign pend_o  = pend_q;
  assign en_o    = (state_q == T_RUN);
  assign intr_o  = intr_q;

endmodule

// File: rtl/otter_io_responder.sv
// OTTER IOBUS peripheral: address decode, zero-latency read mux, LED/7-seg
// registers, switch synchroniser and the countdown timer.
module otter_io_responder
  import otter_io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1100_0000,
  parameter int          PRESCALE_W = 8,
  parameter int          SW_W       = 16
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [31:0]     IOBUS_ADDR,
  input  logic [31:0]     IOBUS_OUT,
  input  logic            IOBUS_WR,
  output logic [31:0]     IOBUS_IN,
  input  logic [SW_W-1:0] SWITCHES,
  output logic [SW_W-1:0] LEDS,
  output logic [15:0]     SSEG_VAL,
  output logic            INTR
);

  logic [31:0]     addr_diff;
  logic            in_win;
  logic [7:0]      ofs;
  logic            wr_leds, wr_sseg, wr_tctrl, wr_tload, wr_tstat;
  logic [SW_W-1:0] sw_meta_q, sw_sync_q;
  logic [SW_W-1:0] leds_q, leds_d;
  logic [15:0]     sseg_q, sseg_d;
  tctrl_t          ctrl_wval;
  tctrl_t          tmr_ctrl;
  logic [31:0]     tmr_count, tmr_tload;
  logic            tmr_pend, tmr_en;

  // Unsigned wrap makes addresses below the base land far outside the window.
  assign addr_diff = IOBUS_ADDR - BASE_ADDR;
  assign in_win    = (addr_diff[31:8] == 24'h0);
  assign ofs       = addr_diff[7:0] & 8'hFC;

  assign wr_leds  = IOBUS_WR && in_win && (ofs == LEDS_OFS);
  assign wr_sseg  = IOBUS_WR && in_win && (ofs == SSEG_OFS);
  assign wr_tctrl = IOBUS_WR && in_win && (ofs == TCTRL_OFS);
  assign wr_tload = IOBUS_WR && in_win && (ofs == TLOAD_OFS);
  assign wr_tstat = IOBUS_WR && in_win && (ofs == TSTAT_OFS);

  always_comb begin
    ctrl_wval       = '0;
    ctrl_wval.presc = IOBUS_OUT[TCTRL_PRESC_LSB +: TCTRL_PRESC_W];
    ctrl_wval.ie    = IOBUS_OUT[TCTRL_IE_BIT];
    ctrl_wval.auto  = IOBUS_OUT[TCTRL_AUTO_BIT];
    ctrl_wval.en    = IOBUS_OUT[TCTRL_EN_BIT];
  end

  assign leds_d = wr_leds ? IOBUS_OUT[SW_W-1:0] : leds_q;
  assign sseg_d = wr_sseg ? IOBUS_OUT[15:0] : sseg_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      leds_q    <= '0;
      sseg_q    <= '0;
    end else begin
      sw_meta_q <= SWITCHES;
      sw_sync_q <= sw_meta_q;
      leds_q    <= leds_d;
      sseg_q    <= sseg_d;
    end
  end

  otter_io_timer #(
    .PRESCALE_W (PRESCALE_W)
  ) u_timer (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .load_wr_i  (wr_tload),
    .load_val_i (IOBUS_OUT),
    .ctrl_wr_i  (wr_tctrl),
    .ctrl_val_i (ctrl_wval),
    .w1c_i      (wr_tstat && IOBUS_OUT[0]),
    .count_o    (tmr_count),
    .tload_o    (tmr_tload),
    .ctrl_o     (tmr_ctrl),
    .pend_o     (tmr_pend),
    .en_o       (tmr_en),
    .intr_o     (INTR)
  );

  always_comb begin
    IOBUS_IN = 32'h0;
    if (in_win) begin
      case (ofs)
        SW_OFS:     IOBUS_IN = 32'(sw_sync_q);
        LEDS_OFS:   IOBUS_IN = 32'(leds_q);
        SSEG_OFS:   IOBUS_IN = {16'h0, sseg_q};
        TCTRL_OFS:  IOBUS_IN = tctrl_word(tmr_ctrl);
        TLOAD_OFS:  IOBUS_IN = tmr_tload;
        TCOUNT_OFS: IOBUS_IN = tmr_count;
        TSTAT_OFS:  IOBUS_IN = {31'h0, tmr_pend};
        default:    IOBUS_IN = 32'h0;
      endcase
    end
  end

  assign LEDS     = leds_q;
  assign SSEG_VAL = sseg_q;

  // EN is also visible through the TCTRL read image; the direct flag is spare.
  logic unused_en;
  assign unused_en = tmr_en;

endmodule

// File: tb/tb_otter_io_responder.sv
// Self-checking bench for otter_io_responder: scoreboard of expected values,
// popped and compared as the DUT outputs are sampled.
module tb_otter_io_responder;

  localparam logic [31:0] BASE = 32'h1100_0000;
  localparam logic [31:0] A_SW     = BASE + 32'h00;
  localparam logic [31:0] A_LEDS   = BASE + 32'h20;
  localparam logic [31:0] A_SSEG   = BASE + 32'h40;
  localparam logic [31:0] A_TCTRL  = BASE + 32'h60;
  localparam logic [31:0] A_TLOAD  = BASE + 32'h64;
  localparam logic [31:0] A_TCOUNT = BASE + 32'h68;
  localparam logic [31:0] A_TSTAT  = BASE + 32'h6C;

  logic        CLK;
  logic        RESET;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] IOBUS_IN;
  logic [15:0] SWITCHES;
  logic [15:0] LEDS;
  logic [15:0] SSEG_VAL;
  logic        INTR;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  otter_io_responder #(
    .BASE_ADDR  (BASE),
    .PRESCALE_W (8),
    .SW_W       (16)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .IOBUS_ADDR (IOBUS_ADDR),
    .IOBUS_OUT  (IOBUS_OUT),
    .IOBUS_WR   (IOBUS_WR),
    .IOBUS_IN   (IOBUS_IN),
    .SWITCHES   (SWITCHES),
    .LEDS       (LEDS),
    .SSEG_VAL   (SSEG_VAL),
    .INTR       (INTR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: act=%h exp=%h", tag, act, exp);
    end else begin
      $display("ok   %s: %h", tag, act);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  task automatic sb_pop(input logic [31:0] act);
    logic [31:0] e;
    string       t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check_eq(t, act, e);
  endtask

  // Zero-latency read: expectation queued with the address, DUT sampled 1ns later.
  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    sb_push(tag, exp);
    IOBUS_ADDR = a;
    #1;
    sb_pop(IOBUS_IN);
  endtask

  task automatic chk_port(input string tag, input logic [31:0] act, input logic [31:0] exp);
    sb_push(tag, exp);
    sb_pop(act);
  endtask

  // Drives a store for exactly one edge; returns 1ns after the committing edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(posedge CLK);
    #1;
    IOBUS_ADDR = a;
    IOBUS_OUT  = d;
    IOBUS_WR   = 1'b1;
    @(posedge CLK);
    #1;
    IOBUS_WR   = 1'b0;
  endtask

  initial begin
    int          ticks, ticks_prev, t;
    logic [31:0] cnt_exp;

    RESET      = 1'b1;
    IOBUS_ADDR = 32'h0;
    IOBUS_OUT  = 32'h0;
    IOBUS_WR   = 1'b0;
    SWITCHES   = 16'h0;
    repeat (2) @(posedge CLK);
    #1;
    chk_port("rst_leds", 32'(LEDS), 32'h0);
    chk_port("rst_intr", 32'(INTR), 32'h0);
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    rd(A_TCTRL, 32'h0, "rst_tctrl");
    rd(A_TCOUNT, 32'h0, "rst_tcount");

    // 1: LEDS / SSEG registers, write to the read-only switch offset
    wr(A_LEDS, 32'hA5A5);
    rd(A_LEDS, 32'hA5A5, "leds_rd");
    chk_port("leds_port", 32'(LEDS), 32'hA5A5);
    wr(A_SW, 32'hFFFF);
    rd(A_LEDS, 32'hA5A5, "leds_after_sw_wr");
    rd(A_SW, 32'h0, "sw_after_sw_wr");
    wr(A_SSEG, 32'h0001_BEEF);
    rd(A_SSEG, 32'hBEEF, "sseg_rd");
    chk_port("sseg_port", 32'(SSEG_VAL), 32'hBEEF);
    rd(BASE + 32'h10, 32'h0, "undef_ofs");
    rd(BASE - 32'hE0, 32'h0, "below_base");

    // 2: switch synchroniser latency
    @(posedge CLK);
    #3;
    SWITCHES = 16'h1234;
    rd(A_SW, 32'h0, "sw_edge0");
    @(posedge CLK);
    #1;
    rd(A_SW, 32'h0, "sw_edge1");
    @(posedge CLK);
    #1;
    rd(A_SW, 32'h1234, "sw_edge2");

    // 3: auto-reload, PRESC=2, L=3; closed-form expectation per edge k
    wr(A_TLOAD, 32'd3);
    wr(A_TCTRL, 32'h0000_0207);
    rd(A_TCTRL, 32'h0000_0207, "tctrl_rd");
    rd(A_TCOUNT, 32'd3, "t3_k0");
    for (int k = 1; k <= 10; k++) begin
      @(posedge CLK);
      #1;
      ticks      = k / 3;
      ticks_prev = (k - 1) / 3;
      t          = ticks % 3;
      cnt_exp    = (t == 0) ? 32'd3 : 32'(3 - t);
      rd(A_TCOUNT, cnt_exp, $sformatf("t3_cnt_k%0d", k));
      rd(A_TSTAT, (ticks >= 3) ? 32'd1 : 32'd0, $sformatf("t3_pend_k%0d", k));
      chk_port($sformatf("t3_intr_k%0d", k), 32'(INTR), (ticks_prev >= 3) ? 32'd1 : 32'd0);
    end
    wr(A_TSTAT, 32'h1);
    chk_port("t3_intr_w1c_edge", 32'(INTR), 32'd1);
    rd(A_TSTAT, 32'd0, "t3_pend_cleared");
    @(posedge CLK);
    #1;
    chk_port("t3_intr_dropped", 32'(INTR), 32'd0);
    wr(A_TCTRL, 32'h0);

    // 4: one-shot, PRESC=0
    wr(A_TLOAD, 32'd2);
    wr(A_TCTRL, 32'h5);
    @(posedge CLK);
    #1;
    rd(A_TCOUNT, 32'd1, "t4_cnt_k1");
    rd(A_TSTAT, 32'd0, "t4_pend_k1");
    @(posedge CLK);
    #1;
    rd(A_TCOUNT, 32'd0, "t4_cnt_k2");
    rd(A_TSTAT, 32'd1, "t4_pend_k2");
    rd(A_TCTRL, 32'h4, "t4_en_off");
    wr(A_TSTAT, 32'h1);
    repeat (5) @(posedge CLK);
    #1;
    rd(A_TSTAT, 32'd0, "t4_no_repend");
    rd(A_TCOUNT, 32'd0, "t4_cnt_held");
    chk_port("t4_intr_low", 32'(INTR), 32'd0);

    // 5a: W1C on the exact expiry edge, set wins
    wr(A_TLOAD, 32'd2);
    wr(A_TCTRL, 32'h5);
    @(posedge CLK);
    #1;
    IOBUS_ADDR = A_TSTAT;
    IOBUS_OUT  = 32'h1;
    IOBUS_WR   = 1'b1;
    @(posedge CLK);
    #1;
    IOBUS_WR = 1'b0;
    rd(A_TSTAT, 32'd1, "t5_set_wins");
    wr(A_TSTAT, 32'h1);
    rd(A_TSTAT, 32'd0, "t5_cleared");

    // 5b: TLOAD write on a tick edge, write wins
    wr(A_TLOAD, 32'd5);
    wr(A_TCTRL, 32'h3);
    IOBUS_ADDR = A_TLOAD;
    IOBUS_OUT  = 32'd9;
    IOBUS_WR   = 1'b1;
    @(posedge CLK);
    #1;
    IOBUS_WR = 1'b0;
    rd(A_TCOUNT, 32'd9, "t5_load_wins");
    @(posedge CLK);
    #1;
    rd(A_TCOUNT, 32'd8, "t5_after_load");
    wr(A_TCTRL, 32'h0);

    // TLOAD=0 expires on the first tick
    wr(A_TLOAD, 32'd0);
    wr(A_TCTRL, 32'h1);
    @(posedge CLK);
    #1;
    rd(A_TSTAT, 32'd1, "tl0_pend");
    rd(A_TCTRL, 32'h0, "tl0_en_off");
    rd(A_TCOUNT, 32'd0, "tl0_cnt");
    wr(A_TSTAT, 32'h1);

    // Outside the window: reads zero, writes ignored (including aliases)
    wr(A_LEDS, 32'h005A);
    rd(BASE + 32'h200, 32'h0, "unmapped_rd");
    wr(BASE + 32'h220, 32'h1111);
    rd(A_LEDS, 32'h005A, "unmapped_wr_leds");
    wr(BASE + 32'h264, 32'h7);
    rd(A_TCOUNT, 32'd0, "unmapped_wr_tload");

    // 6: asynchronous reset mid-count
    wr(A_LEDS, 32'hFFFF);
    wr(A_TLOAD, 32'd2);
    wr(A_TCTRL, 32'h7);
    repeat (6) @(posedge CLK);
    #1;
    chk_port("t6_pre_intr", 32'(INTR), 32'd1);
    chk_port("t6_pre_leds", 32'(LEDS), 32'hFFFF);
    #2;
    RESET = 1'b1;
    #1;
    chk_port("t6_rst_leds", 32'(LEDS), 32'h0);
    chk_port("t6_rst_intr", 32'(INTR), 32'h0);
    chk_port("t6_rst_sseg", 32'(SSEG_VAL), 32'h0);
    rd(A_SW, 32'h0, "t6_rst_sw");
    @(negedge CLK);
    RESET = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    rd(A_TCTRL, 32'h0, "t6_idle_tctrl");
    rd(A_TCOUNT, 32'h0, "t6_idle_tcount");
    rd(A_TSTAT, 32'h0, "t6_idle_pend");
    chk_port("t6_idle_intr", 32'(INTR), 32'h0);

    check_eq("sb_drain", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
